rf_wb_arbiter: RTL

Writeback arbiter for the 32x32 register file's single write port. Two writeback sources share that port: the ALU pipe (requester 0) and the load/store unit (requester 1). The block selects one source per cycle through a valid/ready handshake and registers the winner onto the register file's `reg_write`/`write_reg`/`write_data` inputs. Writes to x0 are handled here, and a starvation counter bounds how long the ALU can wait.

---
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: ALU vs LSU with a
// starvation bound for the ALU. Optional stats counter enabled by RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        rf_reg_write,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        starve_active
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [15:0] conflict_cnt
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic        starve_hit;
    logic        grant_alu;
    logic        grant_lsu;
    logic        write_en_reg;
    logic [4:0]  write_reg_reg;
    logic [31:0] write_data_reg;

    assign starve_hit = (starve_cnt_reg == LIMIT);

    // LSU has default priority; the ALU wins when the LSU is idle or once starved.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!wb_stall) begin
            if (alu_valid && (starve_hit || !lsu_valid)) begin
                grant_alu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!alu_valid || grant_alu) begin
            starve_cnt_next = 4'd0;
        end else if (!wb_stall && !starve_hit) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    // x0 writes complete the handshake but never raise the write enable;
    // address/data hold so the port stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_reg   <= 1'b0;
            write_reg_reg  <= 5'd0;
            write_data_reg <= 32'd0;
            starve_cnt_reg <= 4'd0;
        end else begin
            write_en_reg   <= 1'b0;
            starve_cnt_reg <= starve_cnt_next;
            if (grant_lsu && lsu_rd != 5'd0) begin
                write_en_reg   <= 1'b1;
                write_reg_reg  <= lsu_rd;
                write_data_reg <= lsu_data;
            end else if (grant_alu && alu_rd != 5'd0) begin
                write_en_reg   <= 1'b1;
                write_reg_reg  <= alu_rd;
                write_data_reg <= alu_data;
            end
        end
    end

    assign rf_reg_write  = write_en_reg;
    assign rf_write_reg  = write_reg_reg;
    assign rf_write_data = write_data_reg;
    assign starve_active = starve_hit;

`ifdef RF_WB_ARB_STATS_EN
    logic [15:0] conflict_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_reg <= 16'd0;
        end else if (alu_valid && lsu_valid && !wb_stall && conflict_cnt_reg != 16'hFFFF) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule
